// File: rtl/ram_march_bist_if.sv
// RAM-side bus of the March C- BIST controller.
// master: the BIST controller (port A write, port B read).
// slave:  the dual-port RAM.
interface ram_march_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dia;
  logic              ram_web;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_dib;
  logic [DATA_W-1:0] ram_dob;

  modport master (
    output ram_wea, ram_addra, ram_dia, ram_web, ram_addrb, ram_dib,
    input  ram_dob
  );

  modport slave (
    input  ram_wea, ram_addra, ram_dia, ram_web, ram_addrb, ram_dib,
    output ram_dob
  );
endinterface

// File: rtl/ram_march_bist.sv
// March C- BIST controller for the 32x4 dual-port RAM.
// Port A is used only for writes, port B only for reads.
// Optional macro BIST_STOP_ON_FAIL_EN: the first mismatch ends the test
// immediately (the write of that compare cycle is suppressed).
//
// state | meaning
// IDLE  | waiting for start
// WR0   | element 0: write zeros, one address per cycle
// RD    | present read address on port B
// CMP   | check port-B data, optionally write, advance address/element
// DONE  | one-cycle done pulse, result latched
module ram_march_bist #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic [7:0]        err_count,
  ram_march_bist_if.master  ram
);

  typedef enum logic [2:0] {S_IDLE, S_WR0, S_RD, S_CMP, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] ZERO     = '0;
  localparam logic [DATA_W-1:0] ONES     = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [2:0]        elem, elem_nxt;
  logic [ADDR_W-1:0] addrb_q;
  logic              clear, mismatch, stop_now, last_addr, dir_down;
  logic [DATA_W-1:0] exp_rd, wr_val;
  logic              wea_c;
  logic [ADDR_W-1:0] addra_c;
  logic [DATA_W-1:0] dia_c;

  // Element properties: read expectation, write value, direction.
  always_comb begin
    exp_rd    = (elem == 3'd1 || elem == 3'd3 || elem == 3'd5) ? ZERO : ONES;
    wr_val    = (elem == 3'd1 || elem == 3'd3) ? ONES : ZERO;
    dir_down  = (elem == 3'd3 || elem == 3'd4);
    last_addr = dir_down ? (addr == '0) : (addr == ADDR_MAX);
  end

  // Next-state, address sequencing and RAM port-A / status outputs.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    elem_nxt  = elem;
    clear     = 1'b0;
    mismatch  = 1'b0;
    stop_now  = 1'b0;
    wea_c     = 1'b0;
    addra_c   = '0;
    dia_c     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WR0;
          addr_nxt  = '0;
          elem_nxt  = 3'd0;
          clear     = 1'b1;
        end
      end
      S_WR0: begin
        busy    = 1'b1;
        wea_c   = 1'b1;
        addra_c = addr;
        dia_c   = ZERO;
        if (addr == ADDR_MAX) begin
          state_nxt = S_RD;
          elem_nxt  = 3'd1;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      S_RD: begin
        busy      = 1'b1;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        busy     = 1'b1;
        mismatch = (ram.ram_dob != exp_rd);
`ifdef BIST_STOP_ON_FAIL_EN
        stop_now = mismatch;
`else
        stop_now = 1'b0;
`endif
        if (stop_now) begin
          state_nxt = S_DONE;
        end else begin
          if (elem != 3'd5) begin
            wea_c   = 1'b1;
            addra_c = addr;
            dia_c   = wr_val;
          end
          if (last_addr) begin
            if (elem == 3'd5) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_RD;
              elem_nxt  = elem + 3'd1;
              // E3 and E4 walk downward from the top address.
              addr_nxt  = (elem == 3'd2 || elem == 3'd3) ? ADDR_MAX : '0;
            end
          end else begin
            state_nxt = S_RD;
            addr_nxt  = dir_down ? addr - 1'b1 : addr + 1'b1;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
        addr_nxt  = '0;
        elem_nxt  = 3'd0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, sequencing counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      elem      <= 3'd0;
      addrb_q   <= '0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= 3'd0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      elem  <= elem_nxt;
      if (state == S_RD) addrb_q <= addr;
      if (clear) begin
        pass      <= 1'b0;
        err_count <= 8'd0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_elem <= 3'd0;
      end
      if (mismatch) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0) begin
          fail_addr <= addr;
          fail_data <= ram.ram_dob;
          fail_elem <= elem;
        end
      end
      // Latch the verdict as DONE is entered so it is valid with the pulse.
      if (state == S_CMP && state_nxt == S_DONE)
        pass <= (err_count == 8'd0) && !mismatch;
    end
  end

  // Port B address is only driven fresh in RD and held otherwise.
  assign ram.ram_addrb = (state == S_RD) ? addr : addrb_q;
  assign ram.ram_wea   = wea_c;
  assign ram.ram_addra = addra_c;
  assign ram.ram_dia   = dia_c;
  assign ram.ram_web   = 1'b0;
  assign ram.ram_dib   = '0;

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test controller for the 32x4 dual-port RAM, placed directly upstream of it.
- Drives port A for writes only and port B for reads only, running a March C- sequence over every address.
- Compares port-B read data against the expected background and reports pass/fail, first-failure details and an error count.
- Both RAM clocks are tied to this block's clk at integration.

Parameters:
ADDR_W, 5, RAM address width
DEPTH, 32, number of words tested (2**ADDR_W)
DATA_W, 4, RAM word width

Ports:
clk  input  1  single clock; posedge active
rst  input  1  synchronous, active-high reset
start  input  1  begin test; sampled only in IDLE
busy  output  1  high while a test is running
done  output  1  one-cycle pulse at test end
pass  output  1  1 = no mismatch in last test; held until next start
fail_addr  output  ADDR_W  address of first mismatch
fail_data  output  DATA_W  data read at first mismatch
fail_elem  output  3  March element index (0-5) of first mismatch
err_count  output  8  total mismatches, saturating at 255
ram_wea  output  1  to RAM wea
ram_addra  output  ADDR_W  to RAM addra
ram_dia  output  DATA_W  to RAM dia
ram_web  output  1  to RAM web; constant 0
ram_addrb  output  ADDR_W  to RAM addrb
ram_dib  output  DATA_W  to RAM dib; constant 0
ram_dob  input  DATA_W  from RAM dob

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset is synchronous and active-high on clk, and wins over all other activity; asserted mid-test it aborts the test with no done pulse.
- RAM read timing: RAM latches addrb on the clk edge where web=0; dob is valid during the following cycle.
- March elements (Z = all-zero, O = all-ones of DATA_W):
  - E0: up, w Z
  - E1: up, r Z then w O
  - E2: up, r O then w Z
  - E3: down, r Z then w O
  - E4: down, r O then w Z
  - E5: up, r Z
- States: IDLE, WR0, RD, CMP, DONE.
- IDLE: start=1 at an edge moves to WR0 and clears pass, err_count, fail_addr, fail_data and fail_elem; busy goes high. start is ignored in every other state.
- WR0: one cycle per address; ram_wea=1, ram_addra=addr, ram_dia=Z. addr 0..DEPTH-1, then RD with elem=1, addr=0.
- RD: present ram_addrb=addr; ram_wea=0. Next state CMP.
- CMP: compare ram_dob with the expected value for the element.
  - E1-E4: ram_wea=1, ram_addra=addr, ram_dia=write value.
  - E5: no write.
  - Mismatch: err_count increments (saturating at 255). fail_addr, fail_data and fail_elem are captured only on the first mismatch.
  - Then advance addr (up: 0..31; down: 31..0). At the last address, move to the next element, starting at addr 0 for up or DEPTH-1 for down. After E5, go to DONE.
- DONE: busy=0, done=1 for one cycle; pass=(err_count==0), held. Return to IDLE.
- Timing: a full test holds busy for exactly 352 cycles (32 + 5*64). done is high in cycle 353 after the start-sampling edge.
- Address wrap: counters never wrap within an element. The end-of-element compare uses DEPTH-1 or 0 explicitly.
- ram_web and ram_dib are tied to 0. ram_addrb holds its last value outside RD.

Optional Feature:
- Macro BIST_STOP_ON_FAIL_EN.
- Defined: a mismatch in CMP skips that cycle's write and goes straight to DONE (done pulse next cycle, pass=0, err_count=1).
- Undefined: the test always runs all elements, and err_count accumulates.

Test Plan:
- Fault-free RAM, start pulse -> busy 352 cycles, then done=1 for 1 cycle, pass=1, err_count=0, fail_* = 0.
- RAM addr 9 bit 2 stuck-at-1 (macro off) -> pass=0, fail_elem=1, fail_addr=9, fail_data=4'b0100, err_count=3 (E1, E3, E5).
- Same fault, BIST_STOP_ON_FAIL_EN defined -> done pulse 52 cycles after start; fail_addr=9, fail_elem=1, err_count=1, no write issued at addr 9 in E1.
- rst asserted at cycle 100 of a test -> next cycle all outputs 0, no done pulse. A new start runs the full 352-cycle test, pass=1.
- start held high throughout a test -> ignored while busy. A second test begins only from IDLE after done; pass/err are cleared at that start.
- RAM addr 31 bit 0 stuck-at-0 -> first mismatch fail_elem=2, fail_addr=31, fail_data=4'b1110. err_count=2 (E2, E4).
